// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Forwarding select encoding and multicycle sequencer states live here so the
// top and the forwarding sub-module agree on them.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_MC_TIMEOUT = 64;
  localparam int DEF_CNT_W      = 32;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } mc_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select for the EX stage.
// MEM is the younger producer and so wins over WB; register x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output fwd_sel_e              sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs);
  assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs);

  // Pick the youngest in-flight producer of this operand, else the register file
  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard and sequencing controller for the 5-stage pipeline.
// Drives forwarding selects, load-use stalls, branch flushes and the
// start/done handshake (with timeout watchdog) of the multicycle MUL/DIV unit.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined;
// otherwise stall_cnt/flush_cnt read as zero.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MC_TIMEOUT = DEF_MC_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mc_op,
  input  logic                  ex_branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  mc_done,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_stall,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_bubble,
  output logic                  mc_start,
  output logic                  mc_busy,
  output logic                  mc_error,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int TO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

  mc_state_e       state;
  logic [TO_W-1:0] to_cnt;

  fwd_sel_e fwd_a_sel;
  fwd_sel_e fwd_b_sel;

  logic in_run;
  logic in_wait;
  logic timeout_hit;
  logic mc_release;
  logic mc_hold;
  logic load_use;
  logic branch;

  // ex_reg_write is part of the stage interface but load-use detection keys on
  // ex_mem_read alone, since every load writes a register
  logic unused_inputs;
  assign unused_inputs = ex_reg_write;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a_sel)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b_sel)
  );

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;

  // Controls are held quiet while reset is asserted, even if inputs are active
  assign in_run  = (state == RUN)     && !rst;
  assign in_wait = (state == MC_WAIT) && !rst;

  assign timeout_hit = (to_cnt == TO_LAST);
  assign mc_release  = in_wait && (mc_done || timeout_hit);

  // A multicycle op wins over a simultaneous branch, and suppresses hazards
  assign mc_start = in_run && ex_mc_op;
  assign mc_hold  = mc_start || (in_wait && !mc_release);
  assign mc_busy  = in_wait;

  assign load_use = in_run && !ex_mc_op && ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign branch   = in_run && !ex_mc_op && ex_branch_taken;

  // A taken branch lets the redirected PC load even when a load-use is pending
  assign pc_stall     = mc_hold || (load_use && !branch);
  assign ifid_stall   = mc_hold || (load_use && !branch);
  assign idex_stall   = mc_hold;
  assign exmem_bubble = mc_hold;
  assign ifid_flush   = branch;
  assign idex_bubble  = branch || load_use;

  // Multicycle sequencer: wait for done or give up after MC_TIMEOUT cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      to_cnt   <= '0;
      mc_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ex_mc_op) begin
            state  <= MC_WAIT;
            to_cnt <= '0;
          end
        end
        MC_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (mc_done) begin
            state <= RUN;
          end else if (timeout_hit) begin
            state    <= RUN;
            mc_error <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Count stall and flush cycles; both wrap naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ifid_flush) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a table of single-cycle
// forwarding/load-use/branch vectors, then hand sequences for the multicycle
// handshake, timeout, reset during a wait and the performance counters.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 32;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CW-1:0] EXP_STALL = 32'd6;
  localparam logic [CW-1:0] EXP_FLUSH = 32'd2;
`else
  localparam logic [CW-1:0] EXP_STALL = 32'd0;
  localparam logic [CW-1:0] EXP_FLUSH = 32'd0;
`endif

  logic          clk;
  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs1, id_uses_rs2;
  logic          ex_reg_write, ex_mem_read, ex_mc_op, ex_branch_taken;
  logic          mem_reg_write, wb_reg_write, mc_done;
  logic [1:0]    fwd_a, fwd_b;
  logic          pc_stall, ifid_stall, idex_stall, ifid_flush;
  logic          idex_bubble, exmem_bubble, mc_start, mc_busy, mc_error;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  typedef struct {
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_u1;
    logic          id_u2;
    logic [RW-1:0] ex_rs1;
    logic [RW-1:0] ex_rs2;
    logic [RW-1:0] ex_rd;
    logic          ex_mr;
    logic          ex_br;
    logic [RW-1:0] mem_rd;
    logic          mem_w;
    logic [RW-1:0] wb_rd;
    logic          wb_w;
    logic [1:0]    exp_a;
    logic [1:0]    exp_b;
    logic [7:0]    exp_ctl;
    string         name;
  } vec_t;

  vec_t vecs[13];

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (RW),
    .MC_TIMEOUT (8),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mc_op        (ex_mc_op),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .mc_done         (mc_done),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .idex_stall      (idex_stall),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .exmem_bubble    (exmem_bubble),
    .mc_start        (mc_start),
    .mc_busy         (mc_busy),
    .mc_error        (mc_error),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  // 10 ns pipeline clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {fwd_a, fwd_b, pc_stall, ifid_stall, idex_stall,
  //                 ifid_flush, idex_bubble, exmem_bubble, mc_start, mc_busy}
  function automatic logic [31:0] obs();
    return {20'h0, fwd_a, fwd_b, pc_stall, ifid_stall, idex_stall,
            ifid_flush, idex_bubble, exmem_bubble, mc_start, mc_busy};
  endfunction

  function automatic logic [31:0] expv(input logic [1:0] a, input logic [1:0] b,
                                       input logic [7:0] ctl);
    return {20'h0, a, b, ctl};
  endfunction

  task automatic clearInputs();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mc_op = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
    mc_done = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2;
    id_uses_rs1 = v.id_u1; id_uses_rs2 = v.id_u2;
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
    ex_mem_read = v.ex_mr; ex_reg_write = (v.ex_rd != '0);
    ex_branch_taken = v.ex_br;
    mem_rd = v.mem_rd; mem_reg_write = v.mem_w;
    wb_rd = v.wb_rd; wb_reg_write = v.wb_w;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, ready to drive inputs
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Control bits: {pc,ifid,idex stall, ifid_flush, idex_bub, exmem_bub, start, busy}
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 2'b10, 2'b00, 8'h00, "fwd_mem_priority"};
    vecs[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 5'd3, 1'b1, 2'b01, 2'b00, 8'h00, "fwd_wb_only"};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00, 8'h00, "fwd_x0_never"};
    vecs[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 2'b01, 2'b01, 8'h00, "fwd_both_wb"};
    vecs[4]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd9, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd9, 1'b1, 2'b10, 2'b01, 8'h00, "fwd_split"};
    vecs[5]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 5'd6, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 5'd2, 1'b0, 2'b00, 2'b10, 8'h00, "fwd_b_mem_only"};
    vecs[6]  = '{5'd1, 5'd5, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 8'hC8, "lu_rs2"};
    vecs[7]  = '{5'd1, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 8'h00, "lu_rs2_not_used"};
    vecs[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 8'hC8, "lu_rs1"};
    vecs[9]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 8'h00, "lu_x0"};
    vecs[10] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 8'h18, "lu_plus_branch"};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 8'h18, "branch_only"};
    vecs[12] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 8'h00, "alu_dep_no_stall"};

    $display("[TB] start");

    // Reset with active inputs: every control must stay low
    rst = 1'b1;
    clearInputs();
    ex_branch_taken = 1'b1;
    ex_mc_op = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctl", obs(), expv(2'b00, 2'b00, 8'h00));
    checkOutput("reset_error", {31'h0, mc_error}, 32'h0);
    checkOutput("reset_stall_cnt", stall_cnt, 32'h0);
    checkOutput("reset_flush_cnt", flush_cnt, 32'h0);
    clearInputs();
    #1 rst = 1'b0;

    // Table-driven single-cycle vectors, all evaluated in RUN
    for (int i = 0; i < 13; i++) begin
      nextCycle();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i].name, obs(), expv(vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_ctl));
    end

    // Load-use stalls one cycle, then the load moves to MEM and forwards
    nextCycle();
    clearInputs();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    @(negedge clk);
    checkOutput("lu_cycle", obs(), expv(2'b00, 2'b00, 8'hC8));
    nextCycle();
    clearInputs();
    ex_rs2 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1;
    @(negedge clk);
    checkOutput("lu_released", obs(), expv(2'b00, 2'b10, 8'h00));

    // Multicycle op with done four cycles after start
    nextCycle();
    clearInputs();
    ex_mc_op = 1'b1;
    @(negedge clk);
    checkOutput("mc_start", obs(), expv(2'b00, 2'b00, 8'hE6));
    nextCycle();
    @(negedge clk);
    checkOutput("mc_wait1", obs(), expv(2'b00, 2'b00, 8'hE5));
    nextCycle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    ex_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_write = 1'b1;
    @(negedge clk);
    checkOutput("mc_wait_suppress_lu", obs(), expv(2'b10, 2'b00, 8'hE5));
    nextCycle();
    clearInputs();
    ex_mc_op = 1'b1;
    @(negedge clk);
    checkOutput("mc_wait3", obs(), expv(2'b00, 2'b00, 8'hE5));
    nextCycle();
    mc_done = 1'b1;
    @(negedge clk);
    checkOutput("mc_done_release", obs(), expv(2'b00, 2'b00, 8'h01));
    nextCycle();
    mc_done = 1'b0; ex_mc_op = 1'b0;
    @(negedge clk);
    checkOutput("mc_back_run", obs(), expv(2'b00, 2'b00, 8'h00));
    checkOutput("mc_no_error", {31'h0, mc_error}, 32'h0);
    nextCycle();
    mc_done = 1'b1;
    @(negedge clk);
    checkOutput("mc_done_in_run", obs(), expv(2'b00, 2'b00, 8'h00));
    nextCycle();
    mc_done = 1'b0;
    @(negedge clk);
    checkOutput("run_after_stray_done", obs(), expv(2'b00, 2'b00, 8'h00));

    // Timeout: MC_TIMEOUT=8 wait cycles without done
    nextCycle();
    ex_mc_op = 1'b1;
    @(negedge clk);
    checkOutput("to_start", obs(), expv(2'b00, 2'b00, 8'hE6));
    for (int k = 0; k < 7; k++) begin
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("to_wait%0d", k), obs(), expv(2'b00, 2'b00, 8'hE5));
    end
    nextCycle();
    @(negedge clk);
    checkOutput("to_release", obs(), expv(2'b00, 2'b00, 8'h01));
    checkOutput("to_error_pending", {31'h0, mc_error}, 32'h0);
    nextCycle();
    ex_mc_op = 1'b0;
    @(negedge clk);
    checkOutput("to_back_run", obs(), expv(2'b00, 2'b00, 8'h00));
    checkOutput("to_error_set", {31'h0, mc_error}, 32'h1);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("to_error_sticky", {31'h0, mc_error}, 32'h1);

    // Reset asserted during the second wait cycle
    nextCycle();
    ex_mc_op = 1'b1;
    @(negedge clk);
    checkOutput("rst_mc_start", obs(), expv(2'b00, 2'b00, 8'hE6));
    nextCycle();
    @(negedge clk);
    checkOutput("rst_mc_wait1", obs(), expv(2'b00, 2'b00, 8'hE5));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_async_ctl", obs(), expv(2'b00, 2'b00, 8'h00));
    checkOutput("rst_clears_error", {31'h0, mc_error}, 32'h0);
    ex_mc_op = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("rst_no_restart%0d", k), obs(), expv(2'b00, 2'b00, 8'h00));
    end

    // Performance counters: 1 load-use + 5-cycle mc op + 2 branches
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    clearInputs();
    nextCycle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    nextCycle();
    clearInputs();
    ex_mc_op = 1'b1;
    repeat (4) nextCycle();
    nextCycle();
    mc_done = 1'b1;
    nextCycle();
    mc_done = 1'b0; ex_mc_op = 1'b0;
    ex_branch_taken = 1'b1;
    nextCycle();
    nextCycle();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    checkOutput("perf_stall_cnt", stall_cnt, EXP_STALL);
    checkOutput("perf_flush_cnt", flush_cnt, EXP_FLUSH);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
